// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 raster constants, RGB333 layout and the scanout control bundle.
package video_timing_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int RGB_CH_W = 3;
  localparam int R_LSB    = 6;
  localparam int G_LSB    = 3;
  localparam int B_LSB    = 0;

  localparam logic SYNC_POL_DEF = 1'b0;

  // Control signals that travel alongside the pixel data to the pins.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic frameStart;
    logic blank;
  } vidCtl_t;

  function automatic int cntW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/video_timing_gen.sv
// Raster counters and region decode: active, raw (active-high) syncs, line/frame ends.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = video_timing_pkg::H_ACTIVE,
  parameter int H_FP     = video_timing_pkg::H_FP,
  parameter int H_SYNC   = video_timing_pkg::H_SYNC,
  parameter int H_BP     = video_timing_pkg::H_BP,
  parameter int V_ACTIVE = video_timing_pkg::V_ACTIVE,
  parameter int V_FP     = video_timing_pkg::V_FP,
  parameter int V_SYNC   = video_timing_pkg::V_SYNC,
  parameter int V_BP     = video_timing_pkg::V_BP
) (
  input  logic clk,
  input  logic resetN,
  output logic active,
  output logic vActive,
  output logic hsyncRaw,
  output logic vsyncRaw,
  output logic lineEnd,
  output logic frameEnd,
  output logic vblankStart
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = cntW(HT + 1);
  localparam int VW = cntW(VT + 1);

  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hCount;
  logic [VW-1:0] vCount;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hCount <= '0;
      vCount <= '0;
    end else if (lineEnd) begin
      hCount <= '0;
      vCount <= frameEnd ? '0 : vCount + 1'b1;
    end else begin
      hCount <= hCount + 1'b1;
    end
  end

  assign lineEnd     = (hCount == H_LAST);
  assign frameEnd    = lineEnd && (vCount == V_LAST);
  assign vActive     = (vCount < V_ACT);
  assign active      = vActive && (hCount < H_ACT);
  assign hsyncRaw    = (hCount >= HS_BEG) && (hCount < HS_END);
  assign vsyncRaw    = (vCount >= VS_BEG) && (vCount < VS_END);
  assign vblankStart = (vCount == V_ACT) && (hCount == '0);
endmodule

// File: rtl/framebuffer_scanout.sv
// Scanout: pixel-replicated framebuffer walk with a 2-clk aligned pixel/sync pipeline.
module framebuffer_scanout
  import video_timing_pkg::*;
#(
  parameter int   WIDTH    = 9,
  parameter int   DEPTH    = 2048,
  parameter int   FB_W     = 64,
  parameter int   FB_H     = 32,
  parameter int   HSCALE   = 10,
  parameter int   VSCALE   = 15,
  parameter int   H_FP     = video_timing_pkg::H_FP,
  parameter int   H_SYNC   = video_timing_pkg::H_SYNC,
  parameter int   H_BP     = video_timing_pkg::H_BP,
  parameter int   V_FP     = video_timing_pkg::V_FP,
  parameter int   V_SYNC   = video_timing_pkg::V_SYNC,
  parameter int   V_BP     = video_timing_pkg::V_BP,
  parameter logic SYNC_POL = SYNC_POL_DEF,
  localparam int  AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             blank,
  output logic [AW-1:0]    fbAddress,
  input  logic [WIDTH-1:0] fbData,
  output logic [WIDTH-1:0] rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frameStart
);
  localparam int HSW = cntW(HSCALE);
  localparam int VSW = cntW(VSCALE);
  localparam logic [HSW-1:0] HS_LAST   = HSW'(HSCALE - 1);
  localparam logic [VSW-1:0] VS_LAST   = VSW'(VSCALE - 1);
  localparam logic [AW-1:0]  FB_STRIDE = AW'(FB_W);
  localparam vidCtl_t CTL_IDLE = '{de: 1'b0, hsync: ~SYNC_POL, vsync: ~SYNC_POL,
                                   frameStart: 1'b0, blank: 1'b0};

  logic active, vActive, hsyncRaw, vsyncRaw, lineEnd, frameEnd, vblankStart;

  video_timing_gen #(
    .H_ACTIVE(FB_W * HSCALE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(FB_H * VSCALE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) uTiming (
    .clk(clk), .resetN(resetN), .active(active), .vActive(vActive),
    .hsyncRaw(hsyncRaw), .vsyncRaw(vsyncRaw), .lineEnd(lineEnd),
    .frameEnd(frameEnd), .vblankStart(vblankStart)
  );

  logic [HSW-1:0] hSub;
  logic [VSW-1:0] vSub;
  logic [AW-1:0]  col, lineBase;

  // col runs one past the last pixel at line end; it is only consumed while active.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hSub <= '0;
      col  <= '0;
    end else if (lineEnd) begin
      hSub <= '0;
      col  <= '0;
    end else if (active) begin
      if (hSub == HS_LAST) begin
        hSub <= '0;
        col  <= col + 1'b1;
      end else begin
        hSub <= hSub + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      vSub     <= '0;
      lineBase <= '0;
    end else if (frameEnd) begin
      vSub     <= '0;
      lineBase <= '0;
    end else if (lineEnd && vActive) begin
      if (vSub == VS_LAST) begin
        vSub     <= '0;
        lineBase <= lineBase + FB_STRIDE;
      end else begin
        vSub <= vSub + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)     fbAddress <= '0;
    else if (active) fbAddress <= lineBase + col;
  end

  vidCtl_t ctlIn;
  vidCtl_t ctlPipe [2:1];

  assign ctlIn = '{de: active, hsync: hsyncRaw ? SYNC_POL : ~SYNC_POL,
                   vsync: vsyncRaw ? SYNC_POL : ~SYNC_POL,
                   frameStart: vblankStart, blank: blank};

  // Two stages match the address register plus the framebuffer's read register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ctlPipe[1] <= CTL_IDLE;
      ctlPipe[2] <= CTL_IDLE;
    end else begin
      ctlPipe[1] <= ctlIn;
      ctlPipe[2] <= ctlPipe[1];
    end
  end

  assign de         = ctlPipe[2].de;
  assign hsync      = ctlPipe[2].hsync;
  assign vsync      = ctlPipe[2].vsync;
  assign frameStart = ctlPipe[2].frameStart;
  assign rgb        = (ctlPipe[2].de && !ctlPipe[2].blank) ? fbData : '0;
endmodule
